// File: rtl/wb_port_arbiter.sv
// Two-requester writeback arbiter for the integer register-file write port.
// Tie policy: fixed priority (INT first) by default; define WB_ARB_RR_EN for round-robin.
module wb_port_arbiter #(
    parameter int unsigned DW         = 32,
    parameter int unsigned AW         = 5,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          int_valid,
    output logic          int_ready,
    input  logic [AW-1:0] int_addr,
    input  logic [DW-1:0] int_data,
    input  logic          vec_valid,
    output logic          vec_ready,
    input  logic [AW-1:0] vec_addr,
    input  logic [DW-1:0] vec_data,
    output logic          D_en,
    output logic [AW-1:0] D_Addr,
    output logic [DW-1:0] D_Data,
    output logic          from_VEC,
    output logic [3:0]    starve_cnt
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic          int_hold_v;
    logic [AW-1:0] int_hold_addr;
    logic [DW-1:0] int_hold_data;
    logic          vec_hold_v;
    logic [AW-1:0] vec_hold_addr;
    logic [DW-1:0] vec_hold_data;

    logic both;
    logic starved;
    logic tie_vec;
    logic int_grant;
    logic vec_grant;
    // Which requester the starvation counter is tracking (1 = VEC).
    logic starve_vec;

`ifdef WB_ARB_RR_EN
    // Requester granted on the last two-way arbitration (1 = VEC).
    logic rr_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last <= 1'b1;
        end else if (both) begin
            rr_last <= vec_grant;
        end
    end
`endif

    // Grant selection and ready generation.
    always_comb begin
        both    = int_hold_v & vec_hold_v;
        starved = both && (starve_cnt == STARVE_LIM);
`ifdef WB_ARB_RR_EN
        tie_vec = !rr_last;
`else
        tie_vec = 1'b0;
`endif
        if (both) begin
            vec_grant = starved ? starve_vec : tie_vec;
            int_grant = !vec_grant;
        end else begin
            vec_grant = vec_hold_v;
            int_grant = int_hold_v;
        end
        int_ready = !int_hold_v | int_grant;
        vec_ready = !vec_hold_v | vec_grant;
    end

    // Holding-register payloads need no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (int_valid && int_ready) begin
            int_hold_addr <= int_addr;
            int_hold_data <= int_data;
        end
        if (vec_valid && vec_ready) begin
            vec_hold_addr <= vec_addr;
            vec_hold_data <= vec_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            int_hold_v <= 1'b0;
            vec_hold_v <= 1'b0;
            D_en       <= 1'b0;
            D_Addr     <= '0;
            D_Data     <= '0;
            from_VEC   <= 1'b0;
            starve_cnt <= '0;
            starve_vec <= 1'b1;
        end else begin
            if (int_valid && int_ready) begin
                int_hold_v <= 1'b1;
            end else if (int_grant) begin
                int_hold_v <= 1'b0;
            end
            if (vec_valid && vec_ready) begin
                vec_hold_v <= 1'b1;
            end else if (vec_grant) begin
                vec_hold_v <= 1'b0;
            end

            // Writes to r0 consume the grant but never assert the enable.
            D_en <= 1'b0;
            if (int_grant) begin
                D_en     <= (int_hold_addr != '0);
                D_Addr   <= int_hold_addr;
                D_Data   <= int_hold_data;
                from_VEC <= 1'b0;
            end else if (vec_grant) begin
                D_en     <= (vec_hold_addr != '0);
                D_Addr   <= vec_hold_addr;
                D_Data   <= vec_hold_data;
                from_VEC <= 1'b1;
            end

            // Count consecutive losses of one requester while both are pending.
            if (!both) begin
                starve_cnt <= '0;
            end else if (starve_cnt == '0) begin
                starve_cnt <= CW'(1);
                starve_vec <= int_grant;
            end else if (vec_grant == starve_vec) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter.
module tb_wb_port_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk;
    logic          reset;
    logic          int_valid;
    logic          int_ready;
    logic [AW-1:0] int_addr;
    logic [DW-1:0] int_data;
    logic          vec_valid;
    logic          vec_ready;
    logic [AW-1:0] vec_addr;
    logic [DW-1:0] vec_data;
    logic          D_en;
    logic [AW-1:0] D_Addr;
    logic [DW-1:0] D_Data;
    logic          from_VEC;
    logic [3:0]    starve_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] rf [32];
    int wr_count;
    int saved_wr;

    wb_port_arbiter #(.DW(DW), .AW(AW), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .int_valid(int_valid), .int_ready(int_ready), .int_addr(int_addr), .int_data(int_data),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_addr(vec_addr), .vec_data(vec_data),
        .D_en(D_en), .D_Addr(D_Addr), .D_Data(D_Data), .from_VEC(from_VEC),
        .starve_cnt(starve_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model fed by the write port.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
            wr_count <= 0;
        end else if (D_en) begin
            rf[D_Addr] <= D_Data;
            wr_count   <= wr_count + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; int_valid = 1'b0; vec_valid = 1'b0;
        int_addr = '0; int_data = '0; vec_addr = '0; vec_data = '0;
        do_reset();

        // Reset state
        chk("rst_D_en", 32'(D_en), 32'd0);
        chk("rst_D_Addr", 32'(D_Addr), 32'd0);
        chk("rst_D_Data", D_Data, 32'd0);
        chk("rst_from_VEC", 32'(from_VEC), 32'd0);
        chk("rst_starve", 32'(starve_cnt), 32'd0);
        chk("rst_int_ready", 32'(int_ready), 32'd1);
        chk("rst_vec_ready", 32'(vec_ready), 32'd1);

        // INT only: accept at edge 1, write visible in cycle 3
        int_valid = 1'b1; int_addr = 5'd5; int_data = 32'hDEAD_BEEF;
        step();
        int_valid = 1'b0;
        chk("t1_c2_D_en", 32'(D_en), 32'd0);
        step();
        chk("t1_c3_D_en", 32'(D_en), 32'd1);
        chk("t1_c3_D_Addr", 32'(D_Addr), 32'd5);
        chk("t1_c3_D_Data", D_Data, 32'hDEAD_BEEF);
        chk("t1_c3_from_VEC", 32'(from_VEC), 32'd0);
        step();
        chk("t1_c4_D_en", 32'(D_en), 32'd0);
        chk("t1_c4_D_Addr_hold", 32'(D_Addr), 32'd5);
        chk("t1_rf5", rf[5], 32'hDEAD_BEEF);

        // Both requesters valid every cycle
        int_valid = 1'b1; int_addr = 5'd1; int_data = 32'h1111_0000;
        vec_valid = 1'b1; vec_addr = 5'd2; vec_data = 32'h2222_0000;
        step();
        chk("t2_k1_D_en", 32'(D_en), 32'd0);
        chk("t2_k1_int_ready", 32'(int_ready), 32'd1);
        chk("t2_k1_vec_ready", 32'(vec_ready), 32'd0);
`ifdef WB_ARB_RR_EN
        for (int k = 2; k <= 9; k++) begin
            step();
            chk($sformatf("t3_k%0d_D_en", k), 32'(D_en), 32'd1);
            chk($sformatf("t3_k%0d_from_VEC", k), 32'(from_VEC), 32'(k % 2 == 1));
            chk($sformatf("t3_k%0d_D_Addr", k), 32'(D_Addr), (k % 2 == 1) ? 32'd2 : 32'd1);
            chk($sformatf("t3_k%0d_starve", k), 32'(starve_cnt), (k % 2 == 0) ? 32'd1 : 32'd0);
        end
`else
        for (int k = 2; k <= 11; k++) begin
            step();
            chk($sformatf("t2_k%0d_D_en", k), 32'(D_en), 32'd1);
            chk($sformatf("t2_k%0d_from_VEC", k), 32'(from_VEC), 32'(k % 5 == 1));
            chk($sformatf("t2_k%0d_D_Data", k), D_Data,
                (k % 5 == 1) ? 32'h2222_0000 : 32'h1111_0000);
            chk($sformatf("t2_k%0d_starve", k), 32'(starve_cnt), 32'((k - 1) % 5));
            chk($sformatf("t2_k%0d_int_ready", k), 32'(int_ready), 32'(k % 5 != 0));
            chk($sformatf("t2_k%0d_vec_ready", k), 32'(vec_ready), 32'(k % 5 == 0));
        end
`endif
        int_valid = 1'b0; vec_valid = 1'b0;
        step(); step(); step(); step();
        chk("t2_drain_D_en", 32'(D_en), 32'd0);
        chk("t2_drain_starve", 32'(starve_cnt), 32'd0);

        // Same destination r7 from both sides
        do_reset();
        int_valid = 1'b1; int_addr = 5'd7; int_data = 32'h1;
        vec_valid = 1'b1; vec_addr = 5'd7; vec_data = 32'h2;
        step();
        int_valid = 1'b0; vec_valid = 1'b0;
        step();
        chk("t4_w1_D_en", 32'(D_en), 32'd1);
        chk("t4_w1_D_Data", D_Data, 32'h1);
        chk("t4_w1_from_VEC", 32'(from_VEC), 32'd0);
        step();
        chk("t4_w2_D_en", 32'(D_en), 32'd1);
        chk("t4_w2_D_Addr", 32'(D_Addr), 32'd7);
        chk("t4_w2_D_Data", D_Data, 32'h2);
        chk("t4_w2_from_VEC", 32'(from_VEC), 32'd1);
        step();
        chk("t4_idle_D_en", 32'(D_en), 32'd0);
        chk("t4_rf7_final", rf[7], 32'h2);

        // VEC write to r0 is consumed without enabling the write
        saved_wr = wr_count;
        vec_valid = 1'b1; vec_addr = 5'd0; vec_data = 32'hFFFF_FFFF;
        step();
        vec_valid = 1'b0;
        #1;
        chk("t5_vec_ready", 32'(vec_ready), 32'd1);
        step();
        chk("t5_D_en", 32'(D_en), 32'd0);
        step();
        chk("t5_D_en_after", 32'(D_en), 32'd0);
        chk("t5_vec_ready_idle", 32'(vec_ready), 32'd1);
        chk("t5_rf0", rf[0], 32'h0);
        chk("t5_no_write", 32'(wr_count), 32'(saved_wr));

        // Reset while both holds are pending discards them
        int_valid = 1'b1; int_addr = 5'd3; int_data = 32'hAAAA_AAAA;
        vec_valid = 1'b1; vec_addr = 5'd4; vec_data = 32'hBBBB_BBBB;
        step();
        int_valid = 1'b0; vec_valid = 1'b0;
        reset = 1'b1;
        step();
        chk("t6_rst_D_en", 32'(D_en), 32'd0);
        reset = 1'b0;
        #1;
        chk("t6_int_ready", 32'(int_ready), 32'd1);
        chk("t6_vec_ready", 32'(vec_ready), 32'd1);
        step();
        chk("t6_post1_D_en", 32'(D_en), 32'd0);
        step();
        chk("t6_post2_D_en", 32'(D_en), 32'd0);
        chk("t6_no_write", 32'(wr_count), 32'd0);
        chk("t6_rf3", rf[3], 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
